// File: rtl/bpred_pkg.sv
// ============================================================================
// Module : bpred_pkg
// Brief  : Shared types and the 2-bit direction-counter update for the BTB.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bpred_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_t;

    // Read-side view of one entry; the tag is zero-extended so any TAG_W fits.
    localparam int unsigned BTB_TAG_MAX_W = 32;

    typedef struct packed {
        logic                     valid;
        logic [BTB_TAG_MAX_W-1:0] tag;
        logic [31:0]              target;
        ctr_t                     ctr;
    } btb_entry_t;

    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        ctr_t nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = ctr_t'(ctr + 2'd1);
        end else begin
            if (ctr != SNT) nxt = ctr_t'(ctr - 2'd1);
        end
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bpred_sat_ctr.sv
// ============================================================================
// Module : bpred_sat_ctr
// Brief  : Saturating 2-bit direction counter update used on the training path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bpred_sat_ctr
    import bpred_pkg::*;
(
    input  ctr_t ctr_i,
    input  logic taken_i,
    output ctr_t ctr_o
);

    assign ctr_o = ctr_next(ctr_i, taken_i);

endmodule

`default_nettype wire

// File: rtl/bpred_btb_pc.sv
// ============================================================================
// Module : bpred_btb_pc
// Brief  : Fetch PC generator with a direct-mapped BTB and 2-bit counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bpred_btb_pc
    import bpred_pkg::*;
#(
    parameter int unsigned ENTRIES  = 512,
    parameter int unsigned TAG_W    = 7,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_enable,
    input  logic             dbp_disable,
    input  logic             btb_flush,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             mispredict,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      fetch_pc,
    output logic             predict_taken,
    output logic [31:0]      pred_target,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned TAG_LO = IDX_W + 2;
    localparam int unsigned TAG_HI = IDX_W + TAG_W + 1;

    logic [ENTRIES-1:0] valid_q;
    ctr_t               ctr_q   [ENTRIES];
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [31:0]        tgt_mem [ENTRIES];

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic [CNT_W-1:0] mispred_count_q, mispred_count_d;

    logic [IDX_W-1:0] w_f_idx, w_u_idx;
    logic [TAG_W-1:0] w_f_tag, w_u_tag;
    btb_entry_t       w_rd;
    logic             w_u_hit;
    logic             w_ctr_we;
    logic             w_tgt_we;
    ctr_t             w_ctr_upd;
    ctr_t             w_ctr_new;
    logic             w_unused;

    assign w_f_idx  = fetch_pc_q[IDX_W+1:2];
    assign w_f_tag  = fetch_pc_q[TAG_HI:TAG_LO];
    assign w_u_idx  = upd_pc[IDX_W+1:2];
    assign w_u_tag  = upd_pc[TAG_HI:TAG_LO];
    assign w_unused = ^{upd_pc[31:TAG_HI+1], upd_pc[1:0]};

    always_comb begin
        w_rd        = '0;
        w_rd.valid  = valid_q[w_f_idx];
        w_rd.tag    = BTB_TAG_MAX_W'(tag_mem[w_f_idx]);
        w_rd.target = tgt_mem[w_f_idx];
        w_rd.ctr    = ctr_q[w_f_idx];
    end

    assign predict_taken = w_rd.valid && (w_rd.tag == BTB_TAG_MAX_W'(w_f_tag))
                        && (w_rd.ctr == WT || w_rd.ctr == ST) && !dbp_disable;
    assign pred_target   = w_rd.target;

    // Flush suppresses any same-cycle training write, including the tag/target array.
    assign w_u_hit   = valid_q[w_u_idx] && (tag_mem[w_u_idx] == w_u_tag);
    assign w_ctr_we  = upd_valid && (w_u_hit || upd_taken) && !btb_flush;
    assign w_tgt_we  = upd_valid && upd_taken && !btb_flush;
    assign w_ctr_new = w_u_hit ? w_ctr_upd : WT;

    bpred_sat_ctr u_sat_ctr (
        .ctr_i   (ctr_q[w_u_idx]),
        .taken_i (upd_taken),
        .ctr_o   (w_ctr_upd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= SNT;
            end
        end else if (btb_flush) begin
            valid_q <= '0;
        end else if (w_ctr_we) begin
            valid_q[w_u_idx] <= 1'b1;
            ctr_q[w_u_idx]   <= w_ctr_new;
        end
    end

    always_ff @(posedge clk) begin
        if (w_tgt_we) begin
            tag_mem[w_u_idx] <= w_u_tag;
            tgt_mem[w_u_idx] <= upd_target;
        end
    end

    // A mispredict redirect overrides a fetch stall.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (mispredict) begin
            fetch_pc_d = redirect_pc;
        end else if (pc_enable) begin
            fetch_pc_d = predict_taken ? pred_target : fetch_pc_q + 32'd4;
        end

        hit_count_d = hit_count_q;
        if (predict_taken && pc_enable && (hit_count_q != '1)) begin
            hit_count_d = hit_count_q + CNT_W'(1);
        end

        mispred_count_d = mispred_count_q;
        if (mispredict && (mispred_count_q != '1)) begin
            mispred_count_d = mispred_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q      <= RESET_PC;
            hit_count_q     <= '0;
            mispred_count_q <= '0;
        end else begin
            fetch_pc_q      <= fetch_pc_d;
            hit_count_q     <= hit_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign fetch_pc      = fetch_pc_q;
    assign hit_count     = hit_count_q;
    assign mispred_count = mispred_count_q;

endmodule

`default_nettype wire

// File: tb/tb_bpred_btb_pc.sv
// ============================================================================
// Module : tb_bpred_btb_pc
// Brief  : Self-checking bench for bpred_btb_pc against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bpred_btb_pc;

    localparam int          ENTRIES  = 16;
    localparam int          TAG_W    = 7;
    localparam int          CNT_W    = 4;
    localparam int          IDX_W    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pc_enable = 1'b0;
    logic             dbp_disable = 1'b0;
    logic             btb_flush = 1'b0;
    logic             upd_valid = 1'b0;
    logic [31:0]      upd_pc = '0;
    logic             upd_taken = 1'b0;
    logic [31:0]      upd_target = '0;
    logic             mispredict = 1'b0;
    logic [31:0]      redirect_pc = '0;
    logic [31:0]      fetch_pc;
    logic             predict_taken;
    logic [31:0]      pred_target;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] mispred_count;

    always #5 clk = ~clk;

    bpred_btb_pc #(
        .ENTRIES  (ENTRIES),
        .TAG_W    (TAG_W),
        .RESET_PC (RESET_PC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_enable     (pc_enable),
        .dbp_disable   (dbp_disable),
        .btb_flush     (btb_flush),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .fetch_pc      (fetch_pc),
        .predict_taken (predict_taken),
        .pred_target   (pred_target),
        .hit_count     (hit_count),
        .mispred_count (mispred_count)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: one record per BTB slot plus the architectural PC/counters.
    bit          m_valid [ENTRIES];
    int          m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_pc;
    int          m_hits;
    int          m_mis;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int m_tagof(input logic [31:0] pc);
        return int'((pc >> (2 + IDX_W)) % (1 << TAG_W));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc, input bit dis);
        int i;
        i = m_idx(pc);
        return m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_ctr[i] >= 2) && !dis;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 0;
        end
        m_pc   = RESET_PC;
        m_hits = 0;
        m_mis  = 0;
    endtask

    task automatic step(input bit en, input bit dis, input bit fl, input bit uv,
                        input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                        input bit mp, input logic [31:0] rpc);
        bit p;
        bit hit;
        int i;
        @(negedge clk);
        pc_enable   = en;
        dbp_disable = dis;
        btb_flush   = fl;
        upd_valid   = uv;
        upd_pc      = upc;
        upd_taken   = ut;
        upd_target  = utgt;
        mispredict  = mp;
        redirect_pc = rpc;
        #1;
        p = m_pred(m_pc, dis);
        check("predict_taken", 32'(predict_taken), 32'(p));
        if (p) check("pred_target", pred_target, m_tgt[m_idx(m_pc)]);
        @(posedge clk);
        if (p && en && m_hits < CNT_MAX) m_hits++;
        if (mp && m_mis < CNT_MAX) m_mis++;
        if (mp) m_pc = rpc;
        else if (en) m_pc = p ? m_tgt[m_idx(m_pc)] : m_pc + 32'd4;
        if (fl) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
        end else if (uv) begin
            i   = m_idx(upc);
            hit = m_valid[i] && (m_tag[i] == m_tagof(upc));
            if (hit) begin
                if (ut) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                else    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                if (ut) m_tgt[i] = utgt;
            end else if (ut) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = m_tagof(upc);
                m_tgt[i]   = utgt;
                m_ctr[i]   = 2;
            end
        end
        #1;
        check("fetch_pc", fetch_pc, m_pc);
        check("hit_count", 32'(hit_count), 32'(m_hits));
        check("mispred_count", 32'(mispred_count), 32'(m_mis));
    endtask

    task automatic idle(input bit en);
        step(en, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic train(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
        step(1'b0, 1'b0, 1'b0, 1'b1, pc, taken, tgt, 1'b0, 32'h0);
    endtask

    task automatic jump(input logic [31:0] pc);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, pc);
    endtask

    logic [31:0] pool [8];
    int          mis_before;

    initial begin
        pool[0] = 32'h40;  pool[1] = 32'h44;  pool[2] = 32'h48;  pool[3] = 32'h80;
        pool[4] = 32'h400; pool[5] = 32'h440; pool[6] = 32'h1000; pool[7] = 32'hFFFF_FFFC;

        // Power-on reset
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_fetch_pc", fetch_pc, RESET_PC);
        check("reset_predict", 32'(predict_taken), 32'h0);
        check("reset_hits", 32'(hit_count), 32'h0);
        check("reset_mis", 32'(mispred_count), 32'h0);

        // Sequential fetch
        repeat (4) idle(1'b1);
        check("seq_pc", fetch_pc, 32'h10);

        // Allocate and predict
        train(32'h40, 1'b1, 32'h100);
        jump(32'h40);
        idle(1'b1);
        check("alloc_redirect", fetch_pc, 32'h100);

        // Weaken to strong not-taken, then saturate low
        train(32'h40, 1'b0, 32'h0);
        train(32'h40, 1'b0, 32'h0);
        jump(32'h40);
        idle(1'b1);
        check("weak_nt_pc", fetch_pc, 32'h44);
        repeat (4) train(32'h40, 1'b0, 32'h0);
        jump(32'h40);
        idle(1'b1);
        check("sat_low_pc", fetch_pc, 32'h44);

        // Alias and predictor disable
        train(32'h40, 1'b1, 32'h100);
        train(32'h40, 1'b1, 32'h100);
        jump(32'h40 + 4 * ENTRIES);
        idle(1'b1);
        check("alias_pc", fetch_pc, 32'h40 + 4 * ENTRIES + 4);
        jump(32'h40);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("disable_pc", fetch_pc, 32'h44);
        jump(32'h40);
        idle(1'b1);
        check("enabled_pc", fetch_pc, 32'h100);

        // Redirect during stall, then flush racing an update
        mis_before = int'(mispred_count);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h200);
        check("stall_redirect", fetch_pc, 32'h200);
        check("mis_incr", 32'(mispred_count), 32'(mis_before + 1));
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h500, 1'b0, 32'h0);
        jump(32'h40);
        idle(1'b1);
        check("flush_pc", fetch_pc, 32'h44);

        // Self-loop saturates the hit counter
        train(32'h40, 1'b1, 32'h40);
        jump(32'h40);
        repeat (CNT_MAX + 5) idle(1'b1);
        check("hit_sat", 32'(hit_count), 32'(CNT_MAX));

        // Asynchronous reset in the middle of an update
        @(negedge clk);
        pc_enable  = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 32'h80;
        upd_taken  = 1'b1;
        upd_target = 32'h300;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", fetch_pc, RESET_PC);
        check("async_rst_pred", 32'(predict_taken), 32'h0);
        check("async_rst_hits", 32'(hit_count), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        pc_enable = 1'b0;
        upd_valid = 1'b0;
        upd_taken = 1'b0;
        rst_n     = 1'b1;
        jump(32'h80);
        idle(1'b1);
        check("no_partial_pc", fetch_pc, 32'h84);
        jump(32'h40);
        idle(1'b1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 31) == 0,
                 $urandom_range(0, 1) == 1,
                 pool[$urandom_range(0, 7)],
                 $urandom_range(0, 2) != 0,
                 pool[$urandom_range(0, 7)],
                 $urandom_range(0, 11) == 0,
                 pool[$urandom_range(0, 7)]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
